// File: rtl/rf_pkg.sv
// Shared register-file types and constants used by the write-port arbiter
// and by future read-port schedulers.
package rf_pkg;

    localparam int unsigned RF_ADDR_W   = 5;
    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_NUM_REGS = 1 << RF_ADDR_W;

    typedef enum logic {
        ARB_P0 = 1'b0,
        ARB_P1 = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter with a priority pointer; round-robin when FAIR is set,
// fixed priority to input 0 otherwise.
module rr_arb2
    import rf_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       hold_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    arb_state_e state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_P0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        gnt_o   = '0;
        state_d = state_q;

        if (!hold_i) begin
            if (&req_i) begin
                gnt_o = (state_q == ARB_P0) ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
        end

        // Pointer moves past whoever was just granted; no grant leaves it alone.
        if (FAIR) begin
            if (gnt_o[0]) begin
                state_d = ARB_P1;
            end else if (gnt_o[1]) begin
                state_d = ARB_P0;
            end
        end else begin
            state_d = ARB_P0;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile32 write port between ALU and load writeback, drops
// writes to r0, and exports a mask of the register staged on the port.
module regfile_wr_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned FAIR     = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                hold,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_data,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_data,
    output logic [ADDR_W-1:0]   writeto,
    output logic [DATA_W-1:0]   writedat,
    output logic                writeenable,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic                conflict
);

    wr_req_t       req0, req1, sel;
    logic    [1:0] gnt;
    logic          fire;

    logic [ADDR_W-1:0]   writeto_q, writeto_d;
    logic [DATA_W-1:0]   writedat_q, writedat_d;
    logic                we_q, we_d;
    logic [NUM_REGS-1:0] mask_q, mask_d;
    logic                conflict_q, conflict_d;

    assign req0 = '{valid: req0_valid, addr: req0_addr, data: req0_data};
    assign req1 = '{valid: req1_valid, addr: req1_addr, data: req1_data};

    rr_arb2 #(
        .FAIR (FAIR != 0)
    ) u_arb (
        .clk_i  (clock),
        .rst_ni (reset),
        .hold_i (hold),
        .req_i  ({req1.valid, req0.valid}),
        .gnt_o  (gnt)
    );

    // Readies are gated by reset so nothing is accepted while it is asserted.
    assign req0_ready = gnt[0] & reset;
    assign req1_ready = gnt[1] & reset;

    assign sel  = gnt[1] ? req1 : req0;
    assign fire = (req0_ready | req1_ready) & sel.valid;

    always_comb begin
        writeto_d  = writeto_q;
        writedat_d = writedat_q;
        we_d       = 1'b0;
        mask_d     = '0;
        conflict_d = req0.valid & req1.valid & ~hold;

        if (fire) begin
            writeto_d  = sel.addr;
            writedat_d = sel.data;
            if (sel.addr != '0) begin
                we_d              = 1'b1;
                mask_d[sel.addr]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            writeto_q  <= '0;
            writedat_q <= '0;
            we_q       <= 1'b0;
            mask_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            writeto_q  <= writeto_d;
            writedat_q <= writedat_d;
            we_q       <= we_d;
            mask_q     <= mask_d;
            conflict_q <= conflict_d;
        end
    end

    assign writeto      = writeto_q;
    assign writedat     = writedat_q;
    assign writeenable  = we_q;
    assign pending_mask = mask_q;
    assign conflict     = conflict_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench: one round-robin and one fixed-priority instance share the
// same stimulus; predicted write-port values are queued and compared a cycle later.
module tb_regfile_wr_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          hold;
    logic          r0v, r1v;
    logic [AW-1:0] r0a, r1a;
    logic [DW-1:0] r0d, r1d;

    logic          rr_rdy0, rr_rdy1, rr_we, rr_conf;
    logic [AW-1:0] rr_to;
    logic [DW-1:0] rr_dat;
    logic [NR-1:0] rr_mask;

    logic          fp_rdy0, fp_rdy1, fp_we, fp_conf;
    logic [AW-1:0] fp_to;
    logic [DW-1:0] fp_dat;
    logic [NR-1:0] fp_mask;

    always #5 clock = ~clock;

    regfile_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .FAIR(1)) dut_rr (
        .clock(clock), .reset(reset), .hold(hold),
        .req0_valid(r0v), .req0_ready(rr_rdy0), .req0_addr(r0a), .req0_data(r0d),
        .req1_valid(r1v), .req1_ready(rr_rdy1), .req1_addr(r1a), .req1_data(r1d),
        .writeto(rr_to), .writedat(rr_dat), .writeenable(rr_we),
        .pending_mask(rr_mask), .conflict(rr_conf)
    );

    regfile_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .FAIR(0)) dut_fp (
        .clock(clock), .reset(reset), .hold(hold),
        .req0_valid(r0v), .req0_ready(fp_rdy0), .req0_addr(r0a), .req0_data(r0d),
        .req1_valid(r1v), .req1_ready(fp_rdy1), .req1_addr(r1a), .req1_data(r1d),
        .writeto(fp_to), .writedat(fp_dat), .writeenable(fp_we),
        .pending_mask(fp_mask), .conflict(fp_conf)
    );

    typedef struct {
        logic [AW-1:0] to;
        logic [DW-1:0] dat;
        logic          we;
        logic [NR-1:0] mask;
        logic          conf;
    } exp_t;

    exp_t q_rr[$];
    exp_t q_fp[$];

    // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
    bit            ptr[2];
    logic [AW-1:0] last_to[2];
    logic [DW-1:0] last_dat[2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_gnt(input bit p, input logic h, input logic v0, input logic v1);
        if (h) return 2'b00;
        if (v0 && v1) return p ? 2'b10 : 2'b01;
        return {v1, v0};
    endfunction

    task automatic predict(input int i, output logic [1:0] g, output exp_t e);
        g = model_gnt(ptr[i], hold, r0v, r1v);
        if (g != 2'b00) begin
            last_to[i]  = g[0] ? r0a : r1a;
            last_dat[i] = g[0] ? r0d : r1d;
        end
        e.to   = last_to[i];
        e.dat  = last_dat[i];
        e.we   = (g != 2'b00) && (last_to[i] != '0);
        e.mask = '0;
        if (e.we) e.mask[last_to[i]] = 1'b1;
        e.conf = r0v && r1v && !hold;
        if (i == 0) begin
            if (g[0]) ptr[i] = 1'b1;
            else if (g[1]) ptr[i] = 1'b0;
        end
    endtask

    task automatic cmp_out(input string p, input exp_t e, input logic [AW-1:0] to,
                           input logic [DW-1:0] dat, input logic we,
                           input logic [NR-1:0] mask, input logic conf);
        check({p, "_writeto"}, 64'(to), 64'(e.to));
        check({p, "_writedat"}, 64'(dat), 64'(e.dat));
        check({p, "_writeenable"}, 64'(we), 64'(e.we));
        check({p, "_pending_mask"}, 64'(mask), 64'(e.mask));
        check({p, "_conflict"}, 64'(conf), 64'(e.conf));
    endtask

    // Inputs are already driven; readies checked at the negedge, outputs after the next posedge.
    task automatic step();
        logic [1:0] g;
        exp_t       e;
        @(negedge clock);
        predict(0, g, e);
        check("rr_ready0", 64'(rr_rdy0), 64'(g[0]));
        check("rr_ready1", 64'(rr_rdy1), 64'(g[1]));
        q_rr.push_back(e);
        predict(1, g, e);
        check("fp_ready0", 64'(fp_rdy0), 64'(g[0]));
        check("fp_ready1", 64'(fp_rdy1), 64'(g[1]));
        q_fp.push_back(e);
        @(posedge clock);
        #1;
        e = q_rr.pop_front();
        cmp_out("rr", e, rr_to, rr_dat, rr_we, rr_mask, rr_conf);
        e = q_fp.pop_front();
        cmp_out("fp", e, fp_to, fp_dat, fp_we, fp_mask, fp_conf);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ptr[i]      = 1'b0;
            last_to[i]  = '0;
            last_dat[i] = '0;
        end
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic h);
        r0v = v0; r0a = a0; r0d = d0;
        r1v = v1; r1a = a1; r1d = d1;
        hold = h;
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        drive(1'b1, 5'd1, 32'd200, 1'b0, '0, '0, 1'b0);
        #12;
        check("reset_rr_ready0", 64'(rr_rdy0), 64'd0);
        check("reset_fp_ready0", 64'(fp_rdy0), 64'd0);
        check("reset_rr_we", 64'(rr_we), 64'd0);
        check("reset_rr_mask", 64'(rr_mask), 64'd0);
        check("reset_rr_to", 64'(rr_to), 64'd0);
        check("reset_rr_dat", 64'(rr_dat), 64'd0);
        check("reset_rr_conf", 64'(rr_conf), 64'd0);
        check("reset_fp_we", 64'(fp_we), 64'd0);
        @(posedge clock);
        #1 reset = 1'b1;

        // Single write to r1
        step();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        step();

        // Contention: round-robin alternates, fixed priority always picks requester 0
        drive(1'b1, 5'd2, 32'd300, 1'b1, 5'd3, 32'd3, 1'b0);
        repeat (4) step();
        drive(1'b0, 5'd2, 32'd300, 1'b1, 5'd3, 32'd3, 1'b0);
        step();

        // Write to r0 is accepted but never strobed
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        step();

        // Grant then hold: staged write still lands, new grants stop
        drive(1'b1, 5'd7, 32'd77, 1'b1, 5'd9, 32'd99, 1'b0);
        step();
        hold = 1'b1;
        repeat (3) step();
        hold = 1'b0;
        step();

        // Async reset drops a staged write without a clock edge
        #2 reset = 1'b0;
        #1;
        check("async_rr_we", 64'(rr_we), 64'd0);
        check("async_rr_mask", 64'(rr_mask), 64'd0);
        check("async_fp_we", 64'(fp_we), 64'd0);
        check("async_rr_ready0", 64'(rr_rdy0), 64'd0);
        check("async_fp_ready0", 64'(fp_rdy0), 64'd0);
        model_reset();
        @(posedge clock);
        #1 reset = 1'b1;

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), $urandom,
                  1'($urandom_range(0, 7) == 0));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the 32x32 register file (regfile32) between two writeback requesters: requester 0 is ALU writeback and requester 1 is load/memory writeback.
- Each requester uses a valid/ready handshake. The block arbitrates between them, suppresses writes to register 0, and drives registered writeto/writedat/writeenable into regfile32.
- Exports a pending-write mask so the decode stage can detect a read of a register whose write has not yet landed.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).
- FAIR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority to requester 0.

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low; asserting low clears all state immediately.
- hold  in  1  pipeline stall; while 1, no new request is granted.
- req0_valid  in  1  requester 0 has a write.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  DATA_W  requester 0 write data.
- req1_valid, req1_ready, req1_addr, req1_data  same widths and meaning, for requester 1.
- writeto  out  ADDR_W  regfile write address (registered).
- writedat  out  DATA_W  regfile write data (registered).
- writeenable  out  1  regfile write strobe (registered).
- pending_mask  out  NUM_REGS  bit k = 1 while a write to register k is staged on the write port.
- conflict  out  1  pulses 1 cycle when both requesters were valid and one was refused.

Behaviour:
- Reset (reset=0, asynchronous): writeto=0, writedat=0, writeenable=0, pending_mask=0, conflict=0, round-robin pointer = P0. reqX_ready is combinational and therefore 0 while in reset.
- Arbiter state is two states:
  - P0: requester 0 has priority.
  - P1: requester 1 has priority.
- Grant (combinational, same cycle):
  - If hold=1, both readies are 0.
  - Otherwise, if only one requester is valid, it is granted.
  - If both are valid, the priority holder is granted and the other sees ready=0.
- State transitions:
  - FAIR=1: after a grant to requester 0 the state goes to P1; after a grant to requester 1 it goes to P0.
  - FAIR=1, no grant: the state holds.
  - FAIR=0: the state is fixed at P0.
- Handshake: a transfer occurs on the edge where valid=1 and ready=1. A requester must hold addr and data stable while valid=1 and ready=0. The regfile never back-pressures, so ready depends only on arbitration and hold.
- Latency: transfer at edge N. writeto, writedat and writeenable are presented during cycle N+1, and regfile32 commits at edge N+1. One write per cycle sustained.
- Register 0: a transfer with addr=0 is accepted (ready=1) but writeenable=0 in N+1 and the pending_mask bit is not set. writeto and writedat still update.
- No transfer at edge N: writeenable=0 in N+1. writeto and writedat hold their previous values.
- pending_mask: one-hot of writeto when writeenable=1, else 0. It is registered together with the write port.
- conflict: registered. It is 1 in cycle N+1 when both were valid, hold=0, and one was refused at edge N.
- Same-address requests from both requesters: no merging. Writes are serialized in grant order, so the later grant's data is the final value.
- hold asserted mid-stream: a transfer already accepted still completes in N+1. New grants stop the same cycle hold rises.
- Reset asserted mid-operation: a staged write is discarded (writeenable forced to 0 asynchronously).

Decomposition:
- Shared package rf_pkg:
  - ADDR_W, DATA_W, NUM_REGS constants.
  - Arbiter state encoding (P0=1'b0, P1=1'b1).
  - A write-request struct/bundle {valid, addr, data}, reused by future read-port schedulers.
- One sub-module, rr_arb2: a 2-input round-robin arbiter with a pointer register, producing the grant vector. The parent holds the registered write stage and the mask decode.

Test Plan:
- Reset: drive reset=0 with req0_valid=1 → all outputs 0, ready=0. Release reset; the next cycle req0_ready=1.
- Single write: req0 addr=1 data=200 for one cycle → next cycle writeto=1, writedat=200, writeenable=1, pending_mask=32'h2. Then read regfile32 port 1 → 200.
- Contention: both valid every cycle, req0 addr=2 data=300, req1 addr=3 data=3, FAIR=1 → grants alternate 0,1,0,1. conflict=1 each cycle. Each request is granted within 2 cycles.
- Fixed priority: same stimulus with FAIR=0 → req0 granted every cycle; req1 is never granted until req0_valid drops.
- Register 0: req1 addr=0 data=32'hFFFF_FFFF → req1_ready=1; next cycle writeenable=0, pending_mask=0; register 0 still reads 0.
- Hold and async reset: hold=1 for 3 cycles with both valid → no readies, writeenable=0. Then assert reset mid-cycle after a grant → writeenable drops without a clock edge.
